chan_mux_reg: RTL and testbench
===============================

# chan_mux_reg

Parametrised, registered N-channel, W-bit multiplexer with valid/ready handshakes on every input channel and on the output. It selects channels in one of two modes: fixed selection via `SEL`, or round-robin among valid channels. It is the successor to the team's combinational 8-bit 2:1 mux. It sits wherever several producers share one datapath register stage, for example feeding the ALU operand bus or the output port.

## Interface
- `W`, 8: data width per channel, at least 1.
- `N`, 4: channel count, at least 2.
- `SW`, `$clog2(N)` (derived, local): select and channel-index width.

- `CLK`  in  1  clock; all logic is on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `Input_Data`  in  N*W  channel data, flattened; channel k occupies bits `[k*W +: W]`.
- `Input_Valid`  in  N  per-channel valid.
- `Input_Ready`  out  N  per-channel ready; at most one bit is high per cycle.
- `SEL`  in  SW  channel index used in fixed mode.
- `MODE`  in  1  0 = fixed (`SEL`), 1 = round-robin.
- `MUX_Out`  out  W  registered output data.
- `MUX_Chan`  out  SW  index of the channel held in `MUX_Out`.
- `MUX_Valid`  out  1  output register holds data.
- `MUX_Ready`  in  1  downstream accepts `MUX_Out`.

## Operation
- Output stage is a single register holding `MUX_Out`, `MUX_Chan` and `MUX_Valid`. There is no skid buffer.
- Load enable: `load = !MUX_Valid || MUX_Ready`.
- Grant computation is combinational each cycle.
  - Fixed mode: the grant is `SEL`, provided `Input_Valid[SEL]` is high and `SEL < N`. Otherwise there is no grant.
  - Round-robin mode: search channels `ptr+1, ptr+2, …` with wrap modulo N. The first channel with valid high is granted. If none is valid, there is no grant.
- `Input_Ready[g] = load` for the granted channel g. All other ready bits are 0. With no grant, all ready bits are 0.
- Transfer on channel g occurs when `Input_Valid[g] && Input_Ready[g]`. On that edge:
  - `MUX_Out <= data[g]`, `MUX_Chan <= g`, `MUX_Valid <= 1`.
  - In round-robin mode, `ptr <= g`.
- When `load` is high and there is no grant, `MUX_Valid <= 0`. `MUX_Out` and `MUX_Chan` hold their values.
- When `load` is low (`MUX_Valid && !MUX_Ready`), the whole output register holds. Downstream sees stable data.
- `ptr` (SW bits) is updated only on round-robin transfers. Fixed-mode transfers leave it unchanged.
- Switching `MODE` is allowed on any cycle. The new mode takes effect on that cycle's grant, and the register contents are unaffected.
- `SEL >= N` (non-power-of-2 N) means no grant, and all ready bits are 0.

## Timing
- Reset values: `MUX_Out = 0`, `MUX_Chan = 0`, `MUX_Valid = 0`, `ptr = N-1`. With `ptr = N-1`, channel 0 has first round-robin priority.
- `Input_Ready` is all zero while `RST` is high.
- `RST` asserted mid-transfer: the pending output word is discarded. The input handshake on that cycle does not complete, because ready is forced to 0.
- Latency: input accepted on edge t gives `MUX_Valid` high with the data after edge t.
- Throughput: one word per cycle while `MUX_Ready` is held high.
- Simultaneous output drain and input accept in the same cycle is a legal back-to-back transfer, with no bubble.
- Round-robin pointer wrap: after channel N-1 is granted, the search starts at channel 0.
- `Input_Ready` depends combinationally on `Input_Valid`, `SEL`, `MODE`, `MUX_Ready` and registered state. No ready-to-valid dependency is allowed upstream.

## Test plan
- Reset: with `RST=1` for 2 cycles and all inputs valid, `MUX_Valid=0`, `MUX_Out=0` and `Input_Ready=0`. After release, the first round-robin grant is channel 0.
- Fixed mode, W=8, N=4, `SEL=2`, ch2 data `0xA5` valid, `MUX_Ready=1`: `Input_Ready=4'b0100`, and the next cycle shows `MUX_Out=0xA5`, `MUX_Chan=2`, `MUX_Valid=1`. With ch2 invalid, there is no grant and `MUX_Valid` drops after one cycle.
- Round-robin, all four channels valid, with channel k data `0x10+k` and `MUX_Ready=1`: output sequence is `0x10,0x11,0x12,0x13,0x10` with one word per cycle, confirming wrap.
- Round-robin with only ch1 and ch3 valid: grants alternate 1, 3, 1, 3. Channels 0 and 2 never see ready high.
- Backpressure: output holds `0x11`, `MUX_Ready=0` for 3 cycles. `MUX_Out` and `MUX_Chan` stay stable, all `Input_Ready` bits are 0, and `ptr` is unchanged. On release, the next grant is ch2.
- Mode switch mid-stream from round-robin (ptr=1) to fixed `SEL=0`: the next grant is ch0. Switching back to round-robin resumes the search at ch2, since ptr was unchanged by the fixed-mode transfers.

Source files
------------

// File: rtl/chan_mux_reg_if.sv
// chan_mux_reg_if: channel inputs and registered output bundle for chan_mux_reg.
// Ports: Input_Data/Valid/Ready per channel, SEL/MODE, MUX_Out/Chan/Valid/Ready.
interface chan_mux_reg_if #(
    parameter int W = 8,
    parameter int N = 4
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0] Input_Data;
    logic [N-1:0]   Input_Valid;
    logic [N-1:0]   Input_Ready;
    logic [SW-1:0]  SEL;
    logic           MODE;
    logic [W-1:0]   MUX_Out;
    logic [SW-1:0]  MUX_Chan;
    logic           MUX_Valid;
    logic           MUX_Ready;

    modport master (
        output Input_Data, Input_Valid, SEL, MODE, MUX_Ready,
        input  Input_Ready, MUX_Out, MUX_Chan, MUX_Valid
    );

    modport slave (
        input  Input_Data, Input_Valid, SEL, MODE, MUX_Ready,
        output Input_Ready, MUX_Out, MUX_Chan, MUX_Valid
    );
endinterface

// File: rtl/chan_mux_reg.sv
// chan_mux_reg: registered N-channel W-bit mux, fixed (SEL) or round-robin.
// Ports: CLK, RST (sync, active high), bus (chan_mux_reg_if.slave).
module chan_mux_reg #(
    parameter int W = 8,
    parameter int N = 4
) (
    input logic           CLK,
    input logic           RST,
    chan_mux_reg_if.slave bus
);
    localparam int SW = $clog2(N);

    logic [W-1:0]  out_q, out_d;
    logic [SW-1:0] chan_q, chan_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic          valid_q, valid_d;

    logic          load;
    logic          gnt_vld;
    logic [SW-1:0] gnt;
    logic [SW-1:0] idx;
    logic [W-1:0]  gnt_data;
    logic [N-1:0]  ready;

    assign load = !valid_q || bus.MUX_Ready;

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = '0;
        if (bus.MODE) begin
            // Walk farthest to nearest so the first valid after ptr wins.
            for (int i = N; i >= 1; i--) begin
                idx = SW'((int'(ptr_q) + i) % N);
                if (bus.Input_Valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt     = idx;
                end
            end
        end else begin
            // Out-of-range SEL matches no channel, so no grant.
            for (int k = 0; k < N; k++) begin
                if (bus.SEL == SW'(k) && bus.Input_Valid[k]) begin
                    gnt_vld = 1'b1;
                    gnt     = SW'(k);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt == SW'(k)) begin
                gnt_data = bus.Input_Data[k*W +: W];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (!RST && gnt_vld && load) begin
            ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        out_d   = out_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (gnt_vld) begin
                out_d   = gnt_data;
                chan_d  = gnt;
                valid_d = 1'b1;
                if (bus.MODE) begin
                    ptr_d = gnt;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q   <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= SW'(N - 1);
        end else begin
            out_q   <= out_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.Input_Ready = ready;
    assign bus.MUX_Out     = out_q;
    assign bus.MUX_Chan    = chan_q;
    assign bus.MUX_Valid   = valid_q;
endmodule

// File: tb/tb_chan_mux_reg.sv
// tb_chan_mux_reg: directed bench for chan_mux_reg with a reference model.
// Ports: none (top-level bench).
module tb_chan_mux_reg;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SW = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    chan_mux_reg_if #(.W(W), .N(N)) bus ();

    chan_mux_reg #(.W(W), .N(N)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0]  m_out   = '0;
    logic [SW-1:0] m_chan  = '0;
    logic          m_valid = 1'b0;
    int            m_ptr   = N - 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Candidate list in priority order; first valid one wins, -1 = none.
    function automatic int m_grant();
        int order[$];
        int g = -1;
        if (!bus.MODE) begin
            if (int'(bus.SEL) < N) order.push_back(int'(bus.SEL));
        end else begin
            for (int i = 1; i <= N; i++) order.push_back((m_ptr + i) % N);
        end
        foreach (order[j]) begin
            if (g < 0 && bus.Input_Valid[order[j]]) g = order[j];
        end
        return g;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int g = m_grant();
        logic [N-1:0] r = '0;
        if (!rst && g >= 0 && (!m_valid || bus.MUX_Ready)) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        int g;
        g = m_grant();
        if (rst) begin
            m_out   = '0;
            m_chan  = '0;
            m_valid = 1'b0;
            m_ptr   = N - 1;
        end else if (!m_valid || bus.MUX_Ready) begin
            if (g >= 0) begin
                m_out   = bus.Input_Data[g*W +: W];
                m_chan  = SW'(g);
                m_valid = 1'b1;
                if (bus.MODE) m_ptr = g;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("m_ready", 32'(bus.Input_Ready), 32'(m_ready()));
        check("m_valid", 32'(bus.MUX_Valid), 32'(m_valid));
        check("m_out", 32'(bus.MUX_Out), 32'(m_out));
        check("m_chan", 32'(bus.MUX_Chan), 32'(m_chan));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(int base);
        for (int k = 0; k < N; k++) bus.Input_Data[k*W +: W] = W'(base + k);
    endtask

    task automatic exp_out(string name, int d, int c, int v);
        check({name, "_out"}, 32'(bus.MUX_Out), 32'(d));
        check({name, "_chan"}, 32'(bus.MUX_Chan), 32'(c));
        check({name, "_valid"}, 32'(bus.MUX_Valid), 32'(v));
    endtask

    task automatic exp_rdy(string name, int r);
        #1;
        check(name, 32'(bus.Input_Ready), 32'(r));
    endtask

    initial begin
        rst             = 1'b1;
        bus.MODE        = 1'b1;
        bus.SEL         = '0;
        bus.Input_Valid = '1;
        bus.MUX_Ready   = 1'b1;
        set_data(16);

        cyc();
        cyc();
        exp_out("rst", 0, 0, 0);
        exp_rdy("rst_rdy", 0);
        rst = 1'b0;
        exp_rdy("rel_rdy", 1);

        for (int k = 0; k < 5; k++) begin
            cyc();
            exp_out("rr_all", 16 + (k % N), k % N, 1);
        end

        bus.Input_Valid = 4'b1010;
        for (int j = 0; j < 4; j++) begin
            exp_rdy("rr13_rdy", (j % 2 == 0) ? 4'b0010 : 4'b1000);
            cyc();
            exp_out("rr13", (j % 2 == 0) ? 8'h11 : 8'h13, (j % 2 == 0) ? 1 : 3, 1);
        end

        exp_rdy("bp_pre_rdy", 4'b0010);
        cyc();
        exp_out("bp_load", 8'h11, 1, 1);
        bus.MUX_Ready   = 1'b0;
        bus.Input_Valid = '1;
        for (int j = 0; j < 3; j++) begin
            exp_rdy("bp_rdy", 0);
            cyc();
            exp_out("bp_hold", 8'h11, 1, 1);
            check("bp_ptr", 32'(dut.ptr_q), 32'd1);
        end
        bus.MUX_Ready = 1'b1;
        exp_rdy("bp_rel_rdy", 4'b0100);
        cyc();
        exp_out("bp_rel", 8'h12, 2, 1);

        bus.Input_Valid = 4'b0010;
        exp_rdy("ms_rr_rdy", 4'b0010);
        cyc();
        exp_out("ms_rr", 8'h11, 1, 1);
        bus.MODE        = 1'b0;
        bus.SEL         = '0;
        bus.Input_Valid = '1;
        exp_rdy("ms_fix_rdy", 4'b0001);
        cyc();
        exp_out("ms_fix", 8'h10, 0, 1);
        check("ms_ptr", 32'(dut.ptr_q), 32'd1);
        cyc();
        exp_out("ms_fix2", 8'h10, 0, 1);
        bus.MODE = 1'b1;
        exp_rdy("ms_back_rdy", 4'b0100);
        cyc();
        exp_out("ms_back", 8'h12, 2, 1);

        bus.Input_Data[2*W +: W] = 8'hA5;
        bus.MODE        = 1'b0;
        bus.SEL         = SW'(2);
        bus.Input_Valid = 4'b0100;
        exp_rdy("fx_rdy", 4'b0100);
        cyc();
        exp_out("fx", 8'hA5, 2, 1);
        bus.Input_Valid = 4'b0000;
        exp_rdy("fx_none_rdy", 0);
        cyc();
        exp_out("fx_none", 8'hA5, 2, 0);

        set_data(16);
        bus.Input_Valid = '1;
        bus.MODE        = 1'b1;
        rst             = 1'b1;
        exp_rdy("mid_rst_rdy", 0);
        cyc();
        exp_out("mid_rst", 0, 0, 0);
        check("mid_rst_ptr", 32'(dut.ptr_q), 32'(N - 1));
        rst = 1'b0;
        exp_rdy("post_rst_rdy", 1);
        cyc();
        exp_out("post_rst", 8'h10, 0, 1);

        for (int t = 0; t < 40; t++) begin
            bus.Input_Data  = (N*W)'($urandom);
            bus.Input_Valid = N'($urandom);
            bus.SEL         = SW'($urandom);
            bus.MODE        = 1'($urandom);
            bus.MUX_Ready   = ($urandom_range(0, 3) != 0);
            cyc();
        end
        bus.MUX_Ready = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
